// File: rtl/arm_cu_pkg.sv
// Shared constants for the ARM-subset control unit: control-word layout,
// state indices, datapath select encodings and ALU opcodes.
package arm_cu_pkg;

  localparam int STATE_W = 6;
  localparam int CW_W    = 32;

  // Control-word bit positions, MSB first
  localparam int CW_MFA     = 31;
  localparam int CW_RW_RAM  = 30;
  localparam int CW_SALU    = 29;
  localparam int CW_RF_RW   = 28;
  localparam int CW_SSAB    = 27;
  localparam int CW_SSOP    = 26;
  localparam int CW_SMA     = 25;
  localparam int CW_STA     = 24;
  localparam int CW_MAR_EN  = 23;
  localparam int CW_SR_EN   = 22;
  localparam int CW_MDR_EN  = 21;
  localparam int CW_IR_EN   = 20;
  localparam int CW_SHT_EN  = 19;
  localparam int CW_ISE_EN  = 18;
  localparam int CW_SGN_EN  = 17;
  localparam int CW_CLR     = 16;
  localparam int CW_DSS_HI  = 15;
  localparam int CW_DSS_LO  = 14;
  localparam int CW_WRA_HI  = 13;
  localparam int CW_WRA_LO  = 12;
  localparam int CW_SRA_HI  = 11;
  localparam int CW_SRA_LO  = 10;
  localparam int CW_SRB_HI  = 9;
  localparam int CW_SRB_LO  = 8;
  localparam int CW_SISE_HI = 7;
  localparam int CW_SISE_LO = 6;
  localparam int CW_SALUB_HI = 5;
  localparam int CW_SALUB_LO = 4;
  localparam int CW_ALUA_HI = 3;
  localparam int CW_ALUA_LO = 0;

  typedef enum logic [STATE_W-1:0] {
    S_RESET  = 6'd0,
    S_FETCH0 = 6'd1,
    S_FETCH1 = 6'd2,
    S_FETCH2 = 6'd3,
    S_DECODE = 6'd4,
    S_DP_REG = 6'd10,
    S_DP_IMM = 6'd11,
    S_ADDR   = 6'd12,
    S_LOAD   = 6'd13,
    S_WB     = 6'd14,
    S_STD    = 6'd15,
    S_STORE  = 6'd16,
    S_BR     = 6'd20,
    S_LINK   = 6'd21,
    S_BADD   = 6'd22
  } state_t;

  localparam logic [1:0] WRA_RD  = 2'b00;
  localparam logic [1:0] WRA_RN  = 2'b01;
  localparam logic [1:0] WRA_R15 = 2'b10;
  localparam logic [1:0] WRA_R14 = 2'b11;

  localparam logic [1:0] SRX_RN  = 2'b00;
  localparam logic [1:0] SRX_RD  = 2'b01;
  localparam logic [1:0] SRX_R15 = 2'b10;
  localparam logic [1:0] SRX_RM  = 2'b11;

  localparam logic [1:0] SALUB_SHIFT = 2'b00;
  localparam logic [1:0] SALUB_FOUR  = 2'b01;
  localparam logic [1:0] SALUB_MDR   = 2'b10;
  localparam logic [1:0] SALUB_EXT   = 2'b11;

  localparam logic [1:0] DSS_BYTE = 2'b00;
  localparam logic [1:0] DSS_WORD = 2'b10;

  localparam logic [1:0] SISE_IMM12 = 2'b00;
  localparam logic [1:0] SISE_IMM24 = 2'b10;

  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_MOV = 4'b1101;

endpackage

// File: rtl/arm_cond_check.sv
// ARM condition-code evaluator: pass=1 when the instruction should execute.
module arm_cond_check (
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic c, n, v, z;

  assign c = flags[3];
  assign n = flags[2];
  assign v = flags[1];
  assign z = flags[0];

  always_comb begin
    pass = 1'b0;
    case (cond)
      4'h0: pass = z;
      4'h1: pass = !z;
      4'h2: pass = c;
      4'h3: pass = !c;
      4'h4: pass = n;
      4'h5: pass = !n;
      4'h6: pass = v;
      4'h7: pass = !v;
      4'h8: pass = c && !z;
      4'h9: pass = !c || z;
      4'hA: pass = (n == v);
      4'hB: pass = (n != v);
      4'hC: pass = !z && (n == v);
      4'hD: pass = z || (n != v);
      4'hE: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/arm_control_sequencer.sv
// Multi-cycle ARM-subset control unit: state register plus combinational
// next-state and control-word decode from state and IR fields.
module arm_control_sequencer
  import arm_cu_pkg::*;
(
  input  logic            CLK,
  input  logic            Reset,
  input  logic [31:0]     IR_Out,
  input  logic            MFC,
  input  logic [3:0]      Flags,
  output logic [CW_W-1:0] CW
);

  state_t state, state_nxt;
  logic   cond_pass;
  logic   unused_ir;

  assign unused_ir = ^IR_Out[19:0];

  arm_cond_check u_cond (
    .cond  (IR_Out[31:28]),
    .flags (Flags),
    .pass  (cond_pass)
  );

  always_ff @(posedge CLK) begin
    if (Reset) state <= S_RESET;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = S_FETCH0;
    CW        = '0;
    case (state)
      S_RESET: begin
        CW[CW_CLR] = 1'b1;
      end
      S_FETCH0: begin
        CW[CW_SRB_HI:CW_SRB_LO]     = SRX_R15;
        CW[CW_SALUB_HI:CW_SALUB_LO] = SALUB_SHIFT;
        CW[CW_ALUA_HI:CW_ALUA_LO]   = ALU_MOV;
        CW[CW_MAR_EN]               = 1'b1;
        state_nxt                   = S_FETCH1;
      end
      S_FETCH1: begin
        CW[CW_SRA_HI:CW_SRA_LO]     = SRX_R15;
        CW[CW_SALUB_HI:CW_SALUB_LO] = SALUB_FOUR;
        CW[CW_ALUA_HI:CW_ALUA_LO]   = ALU_ADD;
        CW[CW_RF_RW]                = 1'b1;
        CW[CW_WRA_HI:CW_WRA_LO]     = WRA_R15;
        CW[CW_MFA]                  = 1'b1;
        CW[CW_DSS_HI:CW_DSS_LO]     = DSS_WORD;
        CW[CW_MDR_EN]               = 1'b1;
        state_nxt                   = S_FETCH2;
      end
      S_FETCH2: begin
        CW[CW_MFA]              = 1'b1;
        CW[CW_DSS_HI:CW_DSS_LO] = DSS_WORD;
        CW[CW_IR_EN]            = 1'b1;
        state_nxt               = MFC ? S_DECODE : S_FETCH2;
      end
      S_DECODE: begin
        if (cond_pass) begin
          case (IR_Out[27:25])
            3'b000:  state_nxt = S_DP_REG;
            3'b001:  state_nxt = S_DP_IMM;
            3'b010:  state_nxt = S_ADDR;
            3'b101:  state_nxt = S_BR;
            default: state_nxt = S_FETCH0;
          endcase
        end
      end
      S_DP_REG, S_DP_IMM: begin
        CW[CW_SRA_HI:CW_SRA_LO]     = SRX_RN;
        CW[CW_SRB_HI:CW_SRB_LO]     = SRX_RM;
        CW[CW_SHT_EN]               = 1'b1;
        CW[CW_SALU]                 = 1'b1;
        CW[CW_SALUB_HI:CW_SALUB_LO] = SALUB_SHIFT;
        CW[CW_SR_EN]                = IR_Out[20];
        CW[CW_SSOP]                 = (state == S_DP_IMM);
        // TST/TEQ/CMP/CMN only update flags, never the register file
        CW[CW_RF_RW]                = (IR_Out[24:23] != 2'b10);
        CW[CW_WRA_HI:CW_WRA_LO]     = WRA_RD;
      end
      S_ADDR: begin
        CW[CW_SISE_HI:CW_SISE_LO]   = SISE_IMM12;
        CW[CW_ISE_EN]               = 1'b1;
        CW[CW_SALUB_HI:CW_SALUB_LO] = SALUB_EXT;
        CW[CW_ALUA_HI:CW_ALUA_LO]   = IR_Out[23] ? ALU_ADD : ALU_SUB;
        CW[CW_MAR_EN]               = 1'b1;
        state_nxt                   = IR_Out[20] ? S_LOAD : S_STD;
      end
      S_LOAD: begin
        CW[CW_MFA]              = 1'b1;
        CW[CW_MDR_EN]           = 1'b1;
        CW[CW_DSS_HI:CW_DSS_LO] = IR_Out[22] ? DSS_BYTE : DSS_WORD;
        state_nxt               = MFC ? S_WB : S_LOAD;
      end
      S_WB: begin
        CW[CW_SALUB_HI:CW_SALUB_LO] = SALUB_MDR;
        CW[CW_ALUA_HI:CW_ALUA_LO]   = ALU_MOV;
        CW[CW_RF_RW]                = 1'b1;
        CW[CW_WRA_HI:CW_WRA_LO]     = WRA_RD;
      end
      S_STD: begin
        CW[CW_SRB_HI:CW_SRB_LO]   = SRX_RD;
        CW[CW_ALUA_HI:CW_ALUA_LO] = ALU_MOV;
        CW[CW_MDR_EN]             = 1'b1;
        CW[CW_SMA]                = 1'b1;
        state_nxt                 = S_STORE;
      end
      S_STORE: begin
        CW[CW_MFA]              = 1'b1;
        CW[CW_RW_RAM]           = 1'b1;
        CW[CW_DSS_HI:CW_DSS_LO] = IR_Out[22] ? DSS_BYTE : DSS_WORD;
        state_nxt               = MFC ? S_FETCH0 : S_STORE;
      end
      S_BR: begin
        state_nxt = IR_Out[24] ? S_LINK : S_BADD;
      end
      S_LINK: begin
        CW[CW_SRB_HI:CW_SRB_LO]   = SRX_R15;
        CW[CW_ALUA_HI:CW_ALUA_LO] = ALU_MOV;
        CW[CW_RF_RW]              = 1'b1;
        CW[CW_WRA_HI:CW_WRA_LO]   = WRA_R14;
        state_nxt                 = S_BADD;
      end
      S_BADD: begin
        // PC already holds PC+4 from FETCH1
        CW[CW_SRA_HI:CW_SRA_LO]     = SRX_R15;
        CW[CW_SISE_HI:CW_SISE_LO]   = SISE_IMM24;
        CW[CW_SGN_EN]               = 1'b1;
        CW[CW_SALUB_HI:CW_SALUB_LO] = SALUB_EXT;
        CW[CW_ALUA_HI:CW_ALUA_LO]   = ALU_ADD;
        CW[CW_RF_RW]                = 1'b1;
        CW[CW_WRA_HI:CW_WRA_LO]     = WRA_R15;
      end
      default: begin
        CW        = '0;
        state_nxt = S_FETCH0;
      end
    endcase
  end

endmodule

// File: tb/tb_arm_control_sequencer.sv
// Self-checking bench: expected control words per state queued ahead of time
// and compared cycle by cycle against CW.
module tb_arm_control_sequencer;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] IR_Out = 32'h0;
  logic        MFC = 1'b0;
  logic [3:0]  Flags = 4'h0;
  logic [31:0] CW;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic        mfc_q[$];

  typedef struct {
    logic [31:0] ir;
    logic [3:0]  flags;
    int          p0;
    int          p1;
    int          p2;
    int          plen;
  } vec_t;

  vec_t vecs[14];

  arm_control_sequencer dut (
    .CLK    (CLK),
    .Reset  (Reset),
    .IR_Out (IR_Out),
    .MFC    (MFC),
    .Flags  (Flags),
    .CW     (CW)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] exp_cw(int s, logic [31:0] ir);
    logic [31:0] c;
    c = '0;
    case (s)
      0: c = 32'h0001_0000;
      1: begin c[23] = 1; c[9:8] = 2'b10; c[3:0] = 4'b1101; end
      2: begin
        c[31] = 1; c[28] = 1; c[21] = 1; c[15:14] = 2'b10; c[13:12] = 2'b10;
        c[11:10] = 2'b10; c[5:4] = 2'b01; c[3:0] = 4'b0100;
      end
      3: begin c[31] = 1; c[20] = 1; c[15:14] = 2'b10; end
      10, 11: begin
        c[29] = 1; c[28] = (ir[24:23] != 2'b10); c[22] = ir[20]; c[19] = 1;
        c[9:8] = 2'b11; c[26] = (s == 11);
      end
      12: begin c[23] = 1; c[18] = 1; c[5:4] = 2'b11; c[3:0] = ir[23] ? 4'b0100 : 4'b0010; end
      13: begin c[31] = 1; c[21] = 1; c[15:14] = ir[22] ? 2'b00 : 2'b10; end
      14: begin c[28] = 1; c[5:4] = 2'b10; c[3:0] = 4'b1101; end
      15: begin c[25] = 1; c[21] = 1; c[9:8] = 2'b01; c[3:0] = 4'b1101; end
      16: begin c[31] = 1; c[30] = 1; c[15:14] = ir[22] ? 2'b00 : 2'b10; end
      21: begin c[28] = 1; c[13:12] = 2'b11; c[9:8] = 2'b10; c[3:0] = 4'b1101; end
      22: begin
        c[28] = 1; c[17] = 1; c[13:12] = 2'b10; c[11:10] = 2'b10;
        c[7:6] = 2'b10; c[5:4] = 2'b11; c[3:0] = 4'b0100;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  task automatic check_cw(input string name, input int step, input logic [31:0] exp);
    checks++;
    if (CW !== exp) begin
      failures++;
      $display("FAIL %s step %0d: CW=%h expected %h", name, step, CW, exp);
    end
  endtask

  task automatic push(input int s, input logic mfc);
    exp_q.push_back(exp_cw(s, IR_Out));
    mfc_q.push_back(mfc);
  endtask

  // Called at a negedge: compare current CW, drive MFC, advance one edge.
  task automatic drain(input string name);
    int k = 0;
    while (exp_q.size() > 0) begin
      check_cw(name, k, exp_q.pop_front());
      MFC = mfc_q.pop_front();
      @(posedge CLK);
      @(negedge CLK);
      k++;
    end
  endtask

  initial begin
    vecs[0]  = '{32'hE281_1001, 4'b0000, 11, 0, 0, 1};   // ADD imm
    vecs[1]  = '{32'h0A00_0002, 4'b0000, 0, 0, 0, 0};    // BEQ, Z=0
    vecs[2]  = '{32'h0A00_0002, 4'b0001, 20, 22, 0, 2};  // BEQ, Z=1
    vecs[3]  = '{32'hEB00_0010, 4'b0000, 20, 21, 22, 3}; // BL
    vecs[4]  = '{32'hE591_2000, 4'b0000, 12, 13, 14, 3}; // LDR
    vecs[5]  = '{32'hE581_2000, 4'b0000, 12, 15, 16, 3}; // STR
    vecs[6]  = '{32'hE151_0002, 4'b0000, 10, 0, 0, 1};   // CMP
    vecs[7]  = '{32'hE551_2000, 4'b0000, 12, 13, 14, 3}; // LDRB, down
    vecs[8]  = '{32'hE600_0000, 4'b0000, 0, 0, 0, 0};    // undefined class
    vecs[9]  = '{32'hF281_1001, 4'b1111, 0, 0, 0, 0};    // cond 1111
    vecs[10] = '{32'hC281_1001, 4'b0110, 11, 0, 0, 1};   // GT, N=V=1
    vecs[11] = '{32'h8281_1001, 4'b1001, 0, 0, 0, 0};    // HI, C=1 Z=1
    vecs[12] = '{32'hE091_1002, 4'b0000, 10, 0, 0, 1};   // ADDS reg
    vecs[13] = '{32'hB281_1001, 4'b0100, 11, 0, 0, 1};   // LT, N=1 V=0

    IR_Out = 32'hE281_1001;
    Reset = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_cw("reset_cw", 0, 32'h0001_0000);
    Reset = 1'b0;

    push(0, 0); push(1, 0); push(2, 0);
    repeat (5) push(3, 0);
    push(3, 1); push(4, 1); push(11, 1);
    drain("reset_fetch_wait");

    for (int i = 0; i < 14; i++) begin
      IR_Out = vecs[i].ir;
      Flags  = vecs[i].flags;
      push(1, 1); push(2, 1); push(3, 1); push(4, 1);
      if (vecs[i].plen > 0) push(vecs[i].p0, 1);
      if (vecs[i].plen > 1) push(vecs[i].p1, 1);
      if (vecs[i].plen > 2) push(vecs[i].p2, 1);
      drain($sformatf("vec%0d", i));
    end

    IR_Out = 32'hE591_2000;
    Flags  = 4'b0000;
    push(1, 1); push(2, 1); push(3, 1); push(4, 1); push(12, 1);
    push(13, 0); push(13, 0); push(13, 0); push(13, 1); push(14, 1);
    drain("ldr_mfc_wait");

    IR_Out = 32'hE581_2000;
    push(1, 1); push(2, 1); push(3, 1); push(4, 1); push(12, 1); push(15, 1);
    push(16, 0); push(16, 0); push(16, 1);
    drain("str_mfc_wait");

    IR_Out = 32'hE591_2000;
    push(1, 1); push(2, 1); push(3, 1); push(4, 1); push(12, 0);
    drain("ldr_to_load");
    check_cw("in_load", 0, exp_cw(13, IR_Out));
    MFC = 1'b0;
    Reset = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check_cw("reset_in_load", 0, 32'h0001_0000);
    Reset = 1'b0;
    push(0, 1); push(1, 1); push(2, 1);
    drain("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
